// File: rtl/blade8_mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : blade8_mac_seq_if
// Description : Bundles the job-control, operand-stream, bit-blade PE and
//               result-stream signals of the blade8 MAC sequencer.
//               master : job/operand/result-consumer side plus the PE model
//               slave  : the sequencer itself
//               Signals:
//                 start/len/abort/busy         job control
//                 in_valid/in_ready/in_a/in_b  operand beat stream
//                 pe_in1/pe_in2/pe_out         8x8 bit-blade PE operands/sum
//                 res_valid/res_ready/res_data result stream
// Revision    : 1.0 - initial release
// ============================================================================
interface blade8_mac_seq_if #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 18
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      pe_in1;
  logic [31:0]      pe_in2;
  logic [9:0]       pe_out;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;

  modport master (
    output start, len, abort, in_valid, in_a, in_b, pe_out, res_ready,
    input  busy, in_ready, pe_in1, pe_in2, res_valid, res_data
  );

  modport slave (
    input  start, len, abort, in_valid, in_a, in_b, pe_out, res_ready,
    output busy, in_ready, pe_in1, pe_in2, res_valid, res_data
  );
endinterface
`default_nettype wire

// File: rtl/blade8_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : blade8_mac_seq
// Description : Job sequencer for an external 8x8 bit-blade PE. A job of
//               `len` operand beats is streamed into registered PE operand
//               ports; the PE's one-cycle-latency partial sums are summed
//               into an unsigned accumulator and returned as one result.
//               Ports:
//                 clk   - rising-edge clock
//                 rst_n - asynchronous active-low reset
//                 bus   - blade8_mac_seq_if.slave (control, operand stream,
//                         PE operands/partial sum, result stream)
// Revision    : 1.0 - initial release
// ============================================================================
module blade8_mac_seq #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 18
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  blade8_mac_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_remaining;
  logic [ACC_W-1:0] r_acc;
  logic [31:0]      r_pe_in1;
  logic [31:0]      r_pe_in2;
  // r_v1: beat sitting in pe_in regs; r_v2: its sum is now on pe_out
  logic             r_v1;
  logic             r_v2;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_job_start;

  assign w_in_ready  = (r_state == S_RUN) && (r_remaining != '0);
  assign w_accept    = w_in_ready && bus.in_valid;
  assign w_job_start = (r_state == S_IDLE) && bus.start;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_accept && (r_remaining == LEN_W'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last beat's sum is being accumulated at this edge and nothing
        // is left behind it in the pipeline.
        if (r_v2 && !r_v1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_acc       <= '0;
      r_pe_in1    <= '0;
      r_pe_in2    <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.abort) begin
        r_remaining <= '0;
        r_acc       <= '0;
        r_pe_in1    <= '0;
        r_pe_in2    <= '0;
        r_v1        <= 1'b0;
        r_v2        <= 1'b0;
      end else begin
        // Zero operands on idle cycles keep the PE from seeing stale data.
        r_pe_in1 <= w_accept ? bus.in_a : '0;
        r_pe_in2 <= w_accept ? bus.in_b : '0;
        r_v1     <= w_accept;
        r_v2     <= r_v1;
        if (w_job_start) begin
          r_acc       <= '0;
          r_remaining <= bus.len;
        end else begin
          if (w_accept) begin
            r_remaining <= r_remaining - LEN_W'(1);
          end
          if (r_v2) begin
            r_acc <= r_acc + {{(ACC_W-10){1'b0}}, bus.pe_out};
          end
        end
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.in_ready  = w_in_ready;
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.res_data  = r_acc;
  assign bus.pe_in1    = r_pe_in1;
  assign bus.pe_in2    = r_pe_in2;

endmodule
`default_nettype wire

// File: tb/tb_blade8_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_blade8_mac_seq
// Description : Scoreboard bench for blade8_mac_seq. Includes a behavioural
//               model of the 8x8 bit-blade PE (sum of sixteen 2-bit slice
//               products, one-cycle latency). Expected job results are
//               pushed when a job is issued; a negedge monitor pops and
//               compares whenever a result is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blade8_mac_seq;
  localparam int LEN_W = 8;
  localparam int ACC_W = 18;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic saw_in_ready;
  logic [ACC_W-1:0] exp_q[$];

  blade8_mac_seq_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

  blade8_mac_seq #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] pe_ref(logic [31:0] a, logic [31:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) begin
      s += int'(a[2*i +: 2]) * int'(b[2*i +: 2]);
    end
    return 10'(s);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.pe_out <= '0;
    else        bus.pe_out <= pe_ref(bus.pe_in1, bus.pe_in2);
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.in_ready === 1'b1) saw_in_ready = 1'b1;
    if (rst_n && bus.res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res_valid", 64'(bus.res_valid), 64'd0);
      end else begin
        check("res_data", 64'(bus.res_data), 64'(exp_q[0]));
        if (bus.res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic start_job(input logic [LEN_W-1:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
    int   n;
    logic got;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    forever begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
      if (got) break;
      n++;
      if (n > 200) begin
        check("beat_accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.res_valid) break;
      if (n > 400) begin
        check("res_valid_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
    check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_res_data"},  64'(bus.res_data),  64'd0);
    check({tag, "_pe_in1"},    64'(bus.pe_in1),    64'd0);
    check({tag, "_pe_in2"},    64'(bus.pe_in2),    64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] A01  = 32'h0101_0101;
  localparam logic [31:0] B03  = 32'h0303_0303;

  initial begin
    int n;
    int extra;
    n_cmp = 0;
    n_err = 0;
    saw_in_ready = 1'b0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    check_zero_outputs("in_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("after_reset");

    // len=4, all-ones back-to-back: 4 x 144
    @(posedge clk); #1;
    start_job(8'd4);
    exp_q.push_back(18'd576);
    repeat (4) send_beat(ONES, ONES);
    wait_valid(n);
    check("t1_latency_negedges", 64'(n), 64'd3);
    @(posedge clk); #1;

    // len=0: straight to DONE, no beat ever requested
    saw_in_ready = 1'b0;
    start_job(8'd0);
    exp_q.push_back(18'd0);
    @(negedge clk);
    check("t2_res_valid", 64'(bus.res_valid), 64'd1);
    check("t2_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("t2_back_idle", 64'(bus.busy), 64'd0);
    check("t2_in_ready_seen", 64'(saw_in_ready), 64'd0);
    @(posedge clk); #1;

    // len=3 with 2-cycle gaps: 3 x 12; extra beat must not be taken
    start_job(8'd3);
    exp_q.push_back(18'd36);
    for (int i = 0; i < 3; i++) begin
      send_beat(A01, B03);
      repeat (2) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_a     = ONES;
    bus.in_b     = ONES;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.in_ready) extra++;
    end
    check("t3_extra_beat", 64'(extra), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;

    // len=255 all-ones, result held 10 cycles: 255 x 144
    bus.res_ready = 1'b0;
    start_job(8'd255);
    exp_q.push_back(18'd36720);
    repeat (255) send_beat(ONES, ONES);
    wait_valid(n);
    @(posedge clk); #1;
    bus.start = 1'b1;        // ignored outside IDLE
    bus.len   = 8'd5;
    repeat (9) @(posedge clk);
    #1;
    bus.res_ready = 1'b1;    // handshake; start in same cycle also ignored
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = '0;
    check("t4_idle_after_handshake", 64'(bus.busy), 64'd0);
    check("t4_res_valid_low", 64'(bus.res_valid), 64'd0);
    @(posedge clk); #1;
    check("t4_start_ignored", 64'(bus.busy), 64'd0);

    // Async reset mid-job
    start_job(8'd4);
    send_beat(ONES, ONES);
    send_beat(ONES, ONES);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t5_async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_job(8'd1);
    exp_q.push_back(18'd144);
    send_beat(ONES, ONES);
    wait_valid(n);
    @(posedge clk); #1;

    // Abort in DRAIN
    start_job(8'd2);
    send_beat(ONES, ONES);
    send_beat(ONES, ONES);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("t6_abort_busy", 64'(bus.busy), 64'd0);
    check("t6_abort_pe_in1", 64'(bus.pe_in1), 64'd0);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.res_valid) extra++;
    end
    check("t6_res_valid_rises", 64'(extra), 64'd0);
    @(posedge clk); #1;
    start_job(8'd1);
    exp_q.push_back(18'd12);
    send_beat(A01, B03);
    wait_valid(n);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard_left", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/blade8_mac_seq.md
BLADE8_MAC_SEQ -- requirements
Module: blade8_mac_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the beat-count field.
REQ-002 SHALL have parameter ACC_W, default 18: accumulator/result width, sized so 2^LEN_W-1 beats of 1023 cannot overflow.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-006 SHALL have port len  input  LEN_W  number of operand beats in the job, captured with start.
REQ-007 SHALL have port abort  input  1  synchronous job cancel.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port in_valid  input  1  operand beat valid.
REQ-010 SHALL have port in_ready  output  1  operand beat accepted when in_valid&in_ready.
REQ-011 SHALL have port in_a  input  32  packed unsigned operand A, 4 bytes x four 2-bit slices.
REQ-012 SHALL have port in_b  input  32  packed unsigned operand B, same packing.
REQ-013 SHALL have port pe_in1  output  32  registered operand A to the 8x8 bit-blade PE.
REQ-014 SHALL have port pe_in2  output  32  registered operand B to the PE.
REQ-015 SHALL have port pe_out  input  10  registered PE partial sum, one-cycle PE latency.
REQ-016 SHALL have port res_valid  output  1  result available.
REQ-017 SHALL have port res_ready  input  1  result consumed when res_valid&res_ready.
REQ-018 SHALL have port res_data  output  ACC_W  accumulated dot-product result.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: start=1 with len!=0 SHALL clear accumulator, load remaining=len, go RUN; start=1 with len=0 SHALL clear accumulator and go DONE.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 in_ready SHALL be 1 only in RUN with remaining!=0.
REQ-023 On an accepted beat at edge k, pe_in1/pe_in2 SHALL load in_a/in_b at edge k and remaining SHALL decrement.
REQ-024 On any edge without an accepted beat, pe_in1/pe_in2 SHALL load 0.
REQ-025 A two-stage valid pipeline SHALL track beats; pe_out for a beat accepted at edge k SHALL be added (zero-extended to ACC_W) into the accumulator at edge k+2.
REQ-026 pe_out SHALL only be accumulated when its pipeline valid bit is set.
REQ-027 RUN SHALL go DRAIN at the edge accepting the last beat; DRAIN SHALL go DONE at the edge that accumulates the last beat.
REQ-028 res_valid SHALL be 1 exactly in DONE; res_data SHALL equal the accumulator and stay stable while res_valid=1 and res_ready=0.
REQ-029 DONE with res_ready=1 SHALL go IDLE at that edge; a start in that same cycle SHALL be ignored.
REQ-030 in_valid gaps in RUN SHALL only stall, never corrupt, the job.
REQ-031 abort=1 in any state SHALL at the next edge go IDLE, clear the pipeline valid bits, remaining, accumulator and pe_in registers, deassert res_valid; abort has priority over start and res_ready.
REQ-032 Accumulation SHALL be unsigned; no overflow is possible with default parameters.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, busy=0, in_ready=0, res_valid=0, res_data=0, pe_in1=pe_in2=0, remaining=0, pipeline valid bits=0.
REQ-034 After rst_n rises, the first start SHALL be sampled no earlier than the next rising edge.

Verification
REQ-035 start, len=4, four back-to-back beats in_a=in_b=32'hFFFFFFFF -> res_valid rises 2 edges after last accept, res_data=576.
REQ-036 start, len=0 -> DONE next edge, res_data=0, in_ready never asserted.
REQ-037 len=3, beats in_a=32'h01010101/in_b=32'h03030303 with 2-cycle in_valid gaps -> res_data=36, no extra beat accepted.
REQ-038 len=255, all-ones beats, res_ready held low 10 cycles -> res_data=36720 stable until handshake, then IDLE.
REQ-039 rst_n pulsed low after 2 of 4 beats -> all outputs 0 immediately; new len=1 all-ones job -> res_data=144.
REQ-040 abort asserted in DRAIN -> IDLE next edge, res_valid never rises; following job result unaffected by aborted beats.
